floo_route_return: RTL and testbench
====================================

# floo_route_return

Return-path route computation for a FlooNoC chimney. It records the source endpoint ID of each outgoing AXI request, indexed by AXI transaction ID. On the response path it supplies that ID as the destination ID, so responses return to their originator without an address decoder. It sits between the request packer and the response unpacker and gates requests only where needed to keep the per-ID source mapping unambiguous.

## Interface
Parameters:
- AxiIdWidth, 4, width of the AXI transaction ID; the table has 2**AxiIdWidth entries.
- MaxTxnsPerId, 4, maximum outstanding transactions per AXI ID (≥1).
- id_t, logic, endpoint ID type (scalar ID or XY struct); stored and returned opaquely.

Ports (clock and reset first):
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- req_valid_i  in  1  request valid from the upstream requester.
- req_ready_o  out  1  request ready to the upstream requester.
- req_axi_id_i  in  AxiIdWidth  AXI ID of the request.
- req_src_id_i  in  $bits(id_t)  endpoint ID of the request originator.
- req_valid_o  out  1  request valid forwarded to the network.
- req_ready_i  in  1  network ready for the request.
- rsp_valid_i  in  1  response valid from the network.
- rsp_ready_o  out  1  response ready to the network.
- rsp_axi_id_i  in  AxiIdWidth  AXI ID of the response.
- rsp_last_i  in  1  final beat of the response; only this beat retires a transaction.
- rsp_valid_o  out  1  response valid forwarded downstream.
- rsp_ready_i  in  1  downstream ready.
- rsp_dst_id_o  out  $bits(id_t)  destination ID for the response.
- err_o  out  1  one-cycle pulse when a last beat retires an ID with no outstanding transactions.
- busy_o  out  1  at least one transaction is outstanding.

## Operation
- State: per AXI ID, a src_q entry of type id_t and a cnt_q counter of width $clog2(MaxTxnsPerId+1).
- Request admission: allow = (cnt_q[id]==0) | (cnt_q[id]<MaxTxnsPerId & src_q[id]==req_src_id_i).
  - req_valid_o = req_valid_i & allow.
  - req_ready_o = req_ready_i & allow.
  - Accept condition: req_valid_i & req_ready_o.
- On accept: cnt_q[id] increments. If cnt_q[id] was 0, src_q[id] is loaded with req_src_id_i; otherwise src_q[id] is unchanged.
- Response path is a pass-through: rsp_valid_o = rsp_valid_i and rsp_ready_o = rsp_ready_i.
- rsp_dst_id_o = src_q[rsp_axi_id_i], combinational. When cnt_q for that ID is 0, the output is src_q as-is and carries no meaning.
- Retire condition: rsp_valid_i & rsp_ready_i & rsp_last_i.
  - Normal retire: cnt_q decrements; src_q is left stale.
  - If cnt_q==0: no decrement (no underflow), and err_o pulses high on the next cycle.
- Simultaneous accept and retire:
  - Different IDs: each updates independently.
  - Same ID: count unchanged, src_q unchanged. Admission uses the registered cnt_q only, so a same-cycle retire never frees a slot early.
- busy_o = OR of all (cnt_q != 0), from registers.
- Reset: all cnt_q and src_q are cleared to 0, and err_o=0. Outputs at reset: req_valid_o=req_valid_i, req_ready_o=req_ready_i, rsp_valid_o=rsp_valid_i, rsp_ready_o=rsp_ready_i, rsp_dst_id_o='0, busy_o=0, err_o=0. In-flight transactions are forgotten, and any later last beat for them raises err_o.

## Timing
- Zero-cycle combinational paths:
  - req_*_i → req_*_o, gated by allow.
  - rsp_axi_id_i → rsp_dst_id_o.
- State updates at the clock edge after a handshake. A request accepted in cycle N is visible to admission and busy_o in cycle N+1.
- err_o is registered and high for exactly one cycle (N+1) for a faulty retire in cycle N.
- No combinational path from any ready input to any valid output.
- Full throughput is one request and one response beat per cycle.

## Test plan
- Reset, then a request with id=3, src=0x5, req_ready_i=1 → accepted. Next cycle cnt[3]=1 and busy_o=1. A response with id=3, last=1 gives rsp_dst_id_o=0x5 combinationally; the cycle after that, cnt[3]=0 and busy_o=0.
- Four requests on id=2 with src=0x7 (MaxTxnsPerId=4) → all accepted. A fifth request sees req_ready_o=0 and req_valid_o=0 until one last beat on id=2 retires; it is accepted the cycle after that retire.
- id=1 outstanding with src=0x4; a request on id=1 with src=0x9 → stalled. In the same cycle, a request on id=0 with src=0x9 → accepted. Retiring id=1 to zero allows src=0x9 on id=1 the next cycle.
- Simultaneous accept and retire on id=6 with cnt=2 → cnt stays 2. A multi-beat response with last=0 beats → cnt is unchanged until the last beat.
- Last beat on id=9 with cnt[9]=0 → err_o high for exactly one cycle, cnt[9] stays 0, and the response is still forwarded.
- rst_i asserted mid-stream with cnt[3]=2 → next cycle all counts are 0 and busy_o=0. A subsequent last beat on id=3 pulses err_o.

Source files
------------

// File: rtl/floo_route_return.sv
// -----------------------------------------------------------------------------
// floo_route_return
//
// Return-path route computation for a FlooNoC chimney. Each outgoing AXI
// request has its originator endpoint ID recorded in a table indexed by the
// AXI transaction ID. Responses look up that table so that they travel back
// to their originator without an address decoder.
//
// A request is held back only when accepting it would make the per-ID source
// mapping ambiguous. This happens when the ID is already outstanding with a
// different source, or when the ID has MaxTxnsPerId transactions in flight.
//
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   req_valid_i/o    request valid in (upstream), out (network), gated by allow
//   req_ready_i/o    request ready in (network), out (upstream), gated by allow
//   req_axi_id_i     AXI ID of the request
//   req_src_id_i     endpoint ID of the request originator
//   rsp_valid_i/o    response valid, pass-through
//   rsp_ready_i/o    response ready, pass-through
//   rsp_axi_id_i     AXI ID of the response
//   rsp_last_i       last beat of the response; only this beat retires
//   rsp_dst_id_o     recorded source for rsp_axi_id_i (combinational lookup)
//   err_o            one-cycle pulse: a last beat retired an idle ID
//   busy_o           at least one transaction outstanding
// -----------------------------------------------------------------------------
module floo_route_return #(
  parameter int unsigned AxiIdWidth   = 4,
  parameter int unsigned MaxTxnsPerId = 4,
  parameter type         id_t         = logic
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // request path
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [AxiIdWidth-1:0] req_axi_id_i,
  input  id_t                   req_src_id_i,
  output logic                  req_valid_o,
  input  logic                  req_ready_i,
  // response path
  input  logic                  rsp_valid_i,
  output logic                  rsp_ready_o,
  input  logic [AxiIdWidth-1:0] rsp_axi_id_i,
  input  logic                  rsp_last_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output id_t                   rsp_dst_id_o,
  // status
  output logic                  err_o,
  output logic                  busy_o
);

  localparam int unsigned NumIds   = 2 ** AxiIdWidth;
  localparam int unsigned CntWidth = $clog2(MaxTxnsPerId + 1);

  typedef logic [CntWidth-1:0] cnt_t;

  localparam cnt_t MaxCnt = cnt_t'(MaxTxnsPerId);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  cnt_t cnt_q [NumIds];
  cnt_t cnt_d [NumIds];
  id_t  src_q [NumIds];
  id_t  src_d [NumIds];
  logic err_q, err_d;

  // ---------------------------------------------------------------------------
  // Request admission
  // Admission looks only at registered state. A retire in the same cycle
  // therefore never frees a slot early, and there is no path from any ready
  // input to any valid output.
  // ---------------------------------------------------------------------------
  cnt_t req_cnt;
  id_t  req_src_rec;
  logic req_idle;
  logic req_same_src;
  logic allow;
  logic accept;

  assign req_cnt      = cnt_q[req_axi_id_i];
  assign req_src_rec  = src_q[req_axi_id_i];
  assign req_idle     = (req_cnt == '0);
  assign req_same_src = (req_cnt < MaxCnt) && (req_src_rec == req_src_id_i);
  assign allow        = req_idle || req_same_src;

  assign req_valid_o  = req_valid_i & allow;
  assign req_ready_o  = req_ready_i & allow;
  assign accept       = req_valid_i & req_ready_o;

  // ---------------------------------------------------------------------------
  // Response path: pass-through handshake plus table lookup
  // ---------------------------------------------------------------------------
  logic retire;
  logic rsp_idle;

  assign rsp_valid_o  = rsp_valid_i;
  assign rsp_ready_o  = rsp_ready_i;
  assign rsp_dst_id_o = src_q[rsp_axi_id_i];

  assign retire       = rsp_valid_i & rsp_ready_i & rsp_last_i;
  assign rsp_idle     = (cnt_q[rsp_axi_id_i] == '0);

  // A last beat for an ID with nothing outstanding is reported, not counted.
  assign err_d        = retire & rsp_idle;

  // ---------------------------------------------------------------------------
  // Per-ID decode of the increment / decrement events
  // ---------------------------------------------------------------------------
  logic [NumIds-1:0] inc_hit;
  logic [NumIds-1:0] dec_hit;
  logic [NumIds-1:0] nonzero;

  for (genvar gi = 0; gi < NumIds; gi++) begin : g_id
    assign nonzero[gi] = (cnt_q[gi] != '0);
    assign inc_hit[gi] = accept && (req_axi_id_i == AxiIdWidth'(gi));
    // Decrement only when something is outstanding, so the counter never wraps.
    assign dec_hit[gi] = retire && (rsp_axi_id_i == AxiIdWidth'(gi)) && nonzero[gi];
  end

  assign busy_o = |nonzero;
  assign err_o  = err_q;

  // ---------------------------------------------------------------------------
  // Next-state computation
  // An accept and a retire on the same ID cancel out, so the count stays the
  // same. The source is only (re)loaded when the ID starts from idle. While
  // the ID is busy, the admission check already guarantees the same source.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NumIds; i++) begin
      cnt_d[i] = cnt_q[i];
      src_d[i] = src_q[i];
      if (inc_hit[i] && !dec_hit[i]) begin
        cnt_d[i] = cnt_q[i] + cnt_t'(1);
      end else if (dec_hit[i] && !inc_hit[i]) begin
        cnt_d[i] = cnt_q[i] - cnt_t'(1);
      end
      if (inc_hit[i] && !nonzero[i]) begin
        src_d[i] = req_src_id_i;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumIds; i++) begin
        cnt_q[i] <= '0;
        src_q[i] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NumIds; i++) begin
        cnt_q[i] <= cnt_d[i];
        src_q[i] <= src_d[i];
      end
      err_q <= err_d;
    end
  end

endmodule

// File: tb/tb_floo_route_return.sv
// -----------------------------------------------------------------------------
// tb_floo_route_return
//
// Directed bench for floo_route_return. It uses 4-bit AXI IDs, up to 4
// transactions per ID, and 8-bit endpoint IDs. Inputs change 1 time unit
// after the rising edge, and outputs are sampled before the next edge.
// -----------------------------------------------------------------------------
module tb_floo_route_return;

  localparam int unsigned AxiIdWidth   = 4;
  localparam int unsigned MaxTxnsPerId = 4;
  typedef logic [7:0] ep_t;

  logic            clk;
  logic            rst;
  logic            req_valid_i, req_ready_o, req_valid_o, req_ready_i;
  logic [3:0]      req_axi_id_i;
  ep_t             req_src_id_i;
  logic            rsp_valid_i, rsp_ready_o, rsp_valid_o, rsp_ready_i;
  logic [3:0]      rsp_axi_id_i;
  logic            rsp_last_i;
  ep_t             rsp_dst_id_o;
  logic            err_o, busy_o;

  int n_checks = 0;
  int n_pass   = 0;

  floo_route_return #(
    .AxiIdWidth  (AxiIdWidth),
    .MaxTxnsPerId(MaxTxnsPerId),
    .id_t        (ep_t)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_axi_id_i(req_axi_id_i),
    .req_src_id_i(req_src_id_i),
    .req_valid_o (req_valid_o),
    .req_ready_i (req_ready_i),
    .rsp_valid_i (rsp_valid_i),
    .rsp_ready_o (rsp_ready_o),
    .rsp_axi_id_i(rsp_axi_id_i),
    .rsp_last_i  (rsp_last_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_dst_id_o(rsp_dst_id_o),
    .err_o       (err_o),
    .busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %-24s got 0x%0h", tag, got);
    end else begin
      $display("FAIL %-24s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [3:0] id, input ep_t src);
    req_valid_i  = 1'b1;
    req_ready_i  = 1'b1;
    req_axi_id_i = id;
    req_src_id_i = src;
  endtask

  task automatic req_idle();
    req_valid_i = 1'b0;
  endtask

  task automatic drive_rsp(input logic [3:0] id, input logic last);
    rsp_valid_i  = 1'b1;
    rsp_ready_i  = 1'b1;
    rsp_axi_id_i = id;
    rsp_last_i   = last;
  endtask

  task automatic rsp_idle();
    rsp_valid_i = 1'b0;
    rsp_last_i  = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    req_valid_i  = 1'b1;
    req_ready_i  = 1'b1;
    req_axi_id_i = 4'd3;
    req_src_id_i = 8'h5;
    rsp_valid_i  = 1'b0;
    rsp_ready_i  = 1'b1;
    rsp_axi_id_i = 4'd3;
    rsp_last_i   = 1'b0;

    // ---- reset state ----
    tick();
    tick();
    check("rst_req_valid_o", 32'(req_valid_o), 32'd1);
    check("rst_req_ready_o", 32'(req_ready_o), 32'd1);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_dst", 32'(rsp_dst_id_o), 32'h0);
    rst = 1'b0;
    req_idle();

    // ---- single transaction id=3 src=5 ----
    drive_req(4'd3, 8'h5);
    #1 check("t1_accept", 32'(req_ready_o), 32'd1);
    tick();
    req_idle();
    check("t1_busy_set", 32'(busy_o), 32'd1);
    drive_rsp(4'd3, 1'b1);
    #1 check("t1_dst", 32'(rsp_dst_id_o), 32'h5);
    check("t1_rsp_valid_o", 32'(rsp_valid_o), 32'd1);
    tick();
    rsp_idle();
    check("t1_busy_clr", 32'(busy_o), 32'd0);
    check("t1_err", 32'(err_o), 32'd0);

    // ---- fill id=2 to capacity ----
    for (int k = 0; k < 4; k++) begin
      drive_req(4'd2, 8'h7);
      #1 check($sformatf("t2_fill%0d", k), 32'(req_ready_o), 32'd1);
      tick();
    end
    drive_req(4'd2, 8'h7);
    #1 check("t2_full_ready", 32'(req_ready_o), 32'd0);
    check("t2_full_valid", 32'(req_valid_o), 32'd0);
    drive_rsp(4'd2, 1'b1);
    #1 check("t2_full_during_ret", 32'(req_ready_o), 32'd0);
    tick();
    rsp_idle();
    #1 check("t2_after_ret_ready", 32'(req_ready_o), 32'd1);
    check("t2_after_ret_valid", 32'(req_valid_o), 32'd1);
    tick();
    req_idle();
    for (int k = 0; k < 4; k++) begin
      drive_rsp(4'd2, 1'b1);
      tick();
    end
    rsp_idle();
    check("t2_drained", 32'(busy_o), 32'd0);
    check("t2_err", 32'(err_o), 32'd0);

    // ---- source conflict on id=1 ----
    drive_req(4'd1, 8'h4);
    tick();
    drive_req(4'd1, 8'h9);
    #1 check("t3_conflict_stall", 32'(req_ready_o), 32'd0);
    drive_req(4'd0, 8'h9);
    #1 check("t3_other_id_ok", 32'(req_ready_o), 32'd1);
    tick();
    drive_req(4'd1, 8'h9);
    drive_rsp(4'd1, 1'b1);
    #1 check("t3_dst_id1", 32'(rsp_dst_id_o), 32'h4);
    check("t3_stall_on_ret", 32'(req_ready_o), 32'd0);
    tick();
    rsp_idle();
    #1 check("t3_freed", 32'(req_valid_o), 32'd1);
    tick();
    req_idle();
    drive_rsp(4'd1, 1'b1);
    #1 check("t3_dst_new", 32'(rsp_dst_id_o), 32'h9);
    tick();
    drive_rsp(4'd0, 1'b1);
    #1 check("t3_dst_id0", 32'(rsp_dst_id_o), 32'h9);
    tick();
    rsp_idle();
    check("t3_drained", 32'(busy_o), 32'd0);

    // ---- simultaneous accept+retire on id=6, multi-beat response ----
    drive_req(4'd6, 8'h3);
    tick();
    tick();                      // cnt[6]=2
    drive_rsp(4'd6, 1'b1);       // accept and retire together
    tick();
    rsp_idle();
    drive_req(4'd6, 8'h3);
    #1 check("t4_room_a", 32'(req_ready_o), 32'd1);
    tick();                      // cnt 3
    #1 check("t4_room_b", 32'(req_ready_o), 32'd1);
    tick();                      // cnt 4
    #1 check("t4_full", 32'(req_ready_o), 32'd0);
    for (int k = 0; k < 3; k++) begin
      drive_rsp(4'd6, 1'b0);
      tick();
    end
    rsp_idle();
    #1 check("t4_nonlast_no_ret", 32'(req_ready_o), 32'd0);
    drive_rsp(4'd6, 1'b1);
    tick();
    rsp_idle();
    #1 check("t4_last_ret", 32'(req_ready_o), 32'd1);
    req_idle();
    for (int k = 0; k < 3; k++) begin
      drive_rsp(4'd6, 1'b1);
      tick();
    end
    rsp_idle();
    check("t4_drained", 32'(busy_o), 32'd0);
    check("t4_err", 32'(err_o), 32'd0);

    // ---- faulty retire on idle id=9 ----
    drive_rsp(4'd9, 1'b1);
    #1 check("t5_fwd_valid", 32'(rsp_valid_o), 32'd1);
    check("t5_fwd_ready", 32'(rsp_ready_o), 32'd1);
    tick();
    rsp_idle();
    check("t5_err_pulse", 32'(err_o), 32'd1);
    check("t5_busy", 32'(busy_o), 32'd0);
    tick();
    check("t5_err_one_cycle", 32'(err_o), 32'd0);
    rsp_valid_i = 1'b1;
    rsp_ready_i = 1'b0;
    rsp_last_i  = 1'b1;
    #1 check("t5_ready_passthru", 32'(rsp_ready_o), 32'd0);
    tick();
    rsp_idle();
    rsp_ready_i = 1'b1;
    check("t5_no_hs_no_err", 32'(err_o), 32'd0);

    // ---- reset mid-stream ----
    drive_req(4'd3, 8'h1);
    tick();
    tick();
    req_idle();
    check("t6_busy_pre", 32'(busy_o), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_busy_post", 32'(busy_o), 32'd0);
    drive_rsp(4'd3, 1'b1);
    #1 check("t6_dst_cleared", 32'(rsp_dst_id_o), 32'h0);
    tick();
    rsp_idle();
    check("t6_err_pulse", 32'(err_o), 32'd1);
    tick();
    check("t6_err_clear", 32'(err_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
